// File: rtl/if_pc_gen.sv
// Fetch-side program counter generator: owns the fetch PC, produces PC+4 and the
// wrong-path flush marker for the IF/ID buffer, and parks redirects across stalls.
module if_pc_gen #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180,
    parameter int          CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    input  logic             jump,
    input  logic [31:0]      jump_target,
    input  logic             exc_req,
    output logic [31:0]      pc_fetch,
    output logic [31:0]      out_pc_cal,
    output logic             IF_flush_buf,
    output logic             misalign,
    output logic             pend_valid,
    output logic [CNT_W-1:0] redirect_cnt
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_PEND = 1'b1;

    localparam logic [1:0] PRIO_JMP = 2'd0;
    localparam logic [1:0] PRIO_BR  = 2'd1;
    localparam logic [1:0] PRIO_EXC = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    logic [0:0]       r_state;
    logic [31:0]      r_pc;
    logic [1:0]       r_pend_prio;
    logic [31:0]      r_pend_tgt;
    logic [CNT_W-1:0] r_cnt;

    logic        w_live;
    logic [1:0]  w_live_prio;
    logic [31:0] w_live_raw;
    logic [31:0] w_live_tgt;
    logic        w_take_live;
    logic        w_redirect;
    logic        w_park;
    logic [31:0] w_tgt;

    // Live redirect selection: exception beats branch beats jump.
    always_comb begin
        w_live      = 1'b0;
        w_live_prio = PRIO_JMP;
        w_live_raw  = 32'h0000_0000;
        if (exc_req) begin
            w_live      = 1'b1;
            w_live_prio = PRIO_EXC;
            w_live_raw  = EXC_VECTOR;
        end else if (branch_taken) begin
            w_live      = 1'b1;
            w_live_prio = PRIO_BR;
            w_live_raw  = branch_target;
        end else if (jump) begin
            w_live      = 1'b1;
            w_live_prio = PRIO_JMP;
            w_live_raw  = jump_target;
        end else begin
            w_live      = 1'b0;
        end
    end

    assign w_live_tgt = {w_live_raw[31:2], 2'b00};

    // Redirect arbitration between the live request and any parked one.
    always_comb begin
        w_take_live = 1'b0;
        case (r_state)
            ST_RUN:  w_take_live = w_live;
            // A live request only overtakes a parked one on strictly higher priority.
            ST_PEND: w_take_live = w_live && (w_live_prio > r_pend_prio);
            default: w_take_live = w_live;
        endcase
        w_redirect = enable && (w_live || (r_state == ST_PEND));
        w_park     = !enable && w_live &&
                     ((r_state == ST_RUN) || (w_live_prio >= r_pend_prio));
        if (w_take_live) begin
            w_tgt = w_live_tgt;
        end else begin
            w_tgt = r_pend_tgt;
        end
    end

    // PC, parked-redirect and counter state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= RESET_VECTOR;
            r_state     <= ST_RUN;
            r_pend_prio <= PRIO_JMP;
            r_pend_tgt  <= 32'h0000_0000;
            r_cnt       <= {CNT_W{1'b0}};
        end else if (w_redirect) begin
            r_pc        <= w_tgt;
            r_state     <= ST_RUN;
            r_pend_prio <= PRIO_JMP;
            r_pend_tgt  <= 32'h0000_0000;
            r_cnt       <= sat_inc(r_cnt);
        end else if (enable) begin
            r_pc        <= r_pc + 32'd4;
        end else if (w_park) begin
            r_state     <= ST_PEND;
            r_pend_prio <= w_live_prio;
            r_pend_tgt  <= w_live_tgt;
        end else begin
            r_pc        <= r_pc;
        end
    end

    // Flush is only raised when the buffer is also capturing (enable=1).
    assign IF_flush_buf = !rst && w_redirect;
    assign misalign     = !rst && w_live && (w_live_raw[1:0] != 2'b00);
    assign pend_valid   = !rst && (r_state == ST_PEND);
    assign pc_fetch     = r_pc;
    assign out_pc_cal   = r_pc + 32'd4;
    assign redirect_cnt = r_cnt;

endmodule

// File: tb/tb_if_pc_gen.sv
// Directed bench for if_pc_gen: a behavioural model checked every cycle plus
// hand-computed literal checkpoints.
module tb_if_pc_gen;

    localparam int          CW      = 4;
    localparam int          CNT_SAT = 15;
    localparam logic [31:0] EXC_V   = 32'h8000_0180;

    logic          clk = 1'b0;
    logic          rst, enable, branch_taken, jump, exc_req;
    logic [31:0]   branch_target, jump_target;
    logic [31:0]   pc_fetch, out_pc_cal;
    logic          IF_flush_buf, misalign, pend_valid;
    logic [CW-1:0] redirect_cnt;

    int n_vec = 0;
    int n_err = 0;

    if_pc_gen #(.RESET_VECTOR(32'h0000_0000), .EXC_VECTOR(EXC_V), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target), .exc_req(exc_req),
        .pc_fetch(pc_fetch), .out_pc_cal(out_pc_cal), .IF_flush_buf(IF_flush_buf),
        .misalign(misalign), .pend_valid(pend_valid), .redirect_cnt(redirect_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model state
    logic [31:0] m_pc;
    bit          m_valid = 1'b0;
    bit          m_pend  = 1'b0;
    int          m_pprio = 0;
    logic [31:0] m_ptgt;
    int          m_cnt   = 0;

    // Model compare on the falling edge, then advance to what the next rising edge does.
    initial begin
        forever begin
            int          lp;
            logic [31:0] lraw, ltgt, chosen;
            bit          live, redir;
            @(negedge clk);
            live = exc_req || branch_taken || jump;
            lp   = exc_req ? 2 : (branch_taken ? 1 : (jump ? 0 : -1));
            lraw = exc_req ? EXC_V : (branch_taken ? branch_target : jump_target);
            ltgt = lraw & 32'hFFFF_FFFC;
            redir = enable && (live || m_pend);
            chk("m_flush", {31'd0, IF_flush_buf}, {31'd0, (!rst && redir)});
            chk("m_misalign", {31'd0, misalign}, {31'd0, (!rst && live && (lraw % 4 != 0))});
            chk("m_pend", {31'd0, pend_valid}, {31'd0, (!rst && m_pend)});
            if (m_valid) begin
                chk("m_pc", pc_fetch, m_pc);
                chk("m_pc_cal", out_pc_cal, m_pc + 32'd4);
                chk("m_cnt", {28'd0, redirect_cnt}, m_cnt);
            end
            if (rst) begin
                m_valid = 1'b1; m_pc = 32'h0; m_pend = 1'b0; m_cnt = 0;
            end else if (redir) begin
                chosen = (m_pend && !(live && lp > m_pprio)) ? m_ptgt : ltgt;
                m_pc   = chosen;
                m_pend = 1'b0;
                if (m_cnt < CNT_SAT) m_cnt = m_cnt + 1;
            end else if (enable) begin
                m_pc = m_pc + 32'd4;
            end else if (live && (!m_pend || lp >= m_pprio)) begin
                m_pend = 1'b1; m_pprio = lp; m_ptgt = ltgt;
            end
        end
    end

    task automatic drive(input logic r, input logic en, input logic ex,
                         input logic br, input logic [31:0] bt,
                         input logic jp, input logic [31:0] jt);
        rst = r; enable = en; exc_req = ex;
        branch_taken = br; branch_target = bt; jump = jp; jump_target = jt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic r, input logic en, input logic ex,
                       input logic br, input logic [31:0] bt,
                       input logic jp, input logic [31:0] jt);
        drive(r, en, ex, br, bt, jp, jt);
        tick();
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        // 1. reset + free run
        tick();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("reset_pc", pc_fetch, 32'h0000_0000);
        chk("reset_cnt", {28'd0, redirect_cnt}, 32'd0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("run_pc_c", pc_fetch, 32'h0000_000C);
        chk("run_cal_10", out_pc_cal, 32'h0000_0010);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("run_pc_10", pc_fetch, 32'h0000_0010);

        // 2. branch redirect
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 32'h0);
        #2;
        chk("br_flush", {31'd0, IF_flush_buf}, 32'd1);
        tick();
        chk("br_pc", pc_fetch, 32'h0000_0100);
        chk("br_cnt", {28'd0, redirect_cnt}, 32'd1);

        // 3. redirect during stall
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0040);
        chk("stall_pend", {31'd0, pend_valid}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
            #2;
            chk("stall_noflush", {31'd0, IF_flush_buf}, 32'd0);
            tick();
        end
        chk("stall_pc_hold", pc_fetch, 32'h0000_0100);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        #2;
        chk("release_flush", {31'd0, IF_flush_buf}, 32'd1);
        tick();
        chk("release_pc", pc_fetch, 32'h0000_0040);
        chk("release_pend", {31'd0, pend_valid}, 32'd0);

        // 4. priority
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0700, 1'b1, 32'h0000_0900);
        chk("prio_exc_pc", pc_fetch, 32'h8000_0180);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0200, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0300);
        chk("prio_parked_br", pc_fetch, 32'h0000_0200);
        chk("prio_cnt", {28'd0, redirect_cnt}, 32'd4);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0200, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0500);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0204, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0208, 1'b0, 32'h0);
        chk("prio_equal_replace", pc_fetch, 32'h0000_0204);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0600);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("prio_live_exc_wins", pc_fetch, 32'h8000_0180);

        // 5. boundaries
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
        chk("wrap_pc", pc_fetch, 32'hFFFF_FFFC);
        chk("wrap_cal", out_pc_cal, 32'h0000_0000);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("wrap_next_pc", pc_fetch, 32'h0000_0000);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0103, 1'b0, 32'h0);
        #2;
        chk("misalign_flag", {31'd0, misalign}, 32'd1);
        tick();
        chk("misalign_pc", pc_fetch, 32'h0000_0100);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0020);
        chk("cnt_saturate", {28'd0, redirect_cnt}, 32'd15);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0107, 1'b0, 32'h0);
        chk("pend_before_rst", {31'd0, pend_valid}, 32'd1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        #2;
        chk("rst_comb_pend", {31'd0, pend_valid}, 32'd0);
        tick();
        chk("rst_pend_pc", pc_fetch, 32'h0000_0000);
        chk("rst_pend_cnt", {28'd0, redirect_cnt}, 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("after_rst_pc", pc_fetch, 32'h0000_0004);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("idle_stall_hold", pc_fetch, 32'h0000_0004);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
